// File: rtl/pll_reconfig_sequencer_if.sv
// Request (valid/ready + counter fields) and Avalon-MM management bus of the PLL sequencer.
// "master" is the sequencer side (it masters the Avalon bus); "slave" is requester + reconfig core.
interface pll_reconfig_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_m_hi;
  logic [7:0]  cfg_m_lo;
  logic [7:0]  cfg_n_hi;
  logic [7:0]  cfg_n_lo;
  logic        cfg_n_bypass;
  logic [7:0]  cfg_c0_hi;
  logic [7:0]  cfg_c0_lo;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    input  cfg_valid, cfg_m_hi, cfg_m_lo, cfg_n_hi, cfg_n_lo, cfg_n_bypass, cfg_c0_hi, cfg_c0_lo,
    output cfg_ready,
    output mgmt_address, mgmt_write, mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    output cfg_valid, cfg_m_hi, cfg_m_lo, cfg_n_hi, cfg_n_lo, cfg_n_bypass, cfg_c0_hi, cfg_c0_lo,
    input  cfg_ready,
    input  mgmt_address, mgmt_write, mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_reconfig_sequencer.sv
// Programs M/N/C0 into altera_pll_reconfig over Avalon-MM, then waits for a stable PLL lock.
// Reports done or lock timeout; all outputs decode from the registered state.
module pll_reconfig_sequencer #(
  parameter int unsigned LOCK_TIMEOUT = 1000000,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                             refclk,
  input  logic                             rst,
  pll_reconfig_sequencer_if.master         bus,
  input  logic                             pll_locked,
  output logic                             busy,
  output logic                             done,
  output logic                             err_timeout
);

  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned StbW = $clog2(LOCK_STABLE + 1);

  typedef enum logic [2:0] {
    StIdle, StWrMode, StWrN, StWrM, StWrC0, StWrStart, StWaitLock
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             m_hi_q, m_lo_q, n_hi_q, n_lo_q, c0_hi_q, c0_lo_q;
  logic                   n_byp_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cyc_cnt_q, cyc_cnt_d;
  logic [StbW-1:0]        stable_q, stable_d;
  logic                   accept, locked_s;
  logic [31:0]            n_word, m_word, c0_word;

  assign accept   = (state_q == StIdle) && bus.cfg_valid;
  assign locked_s = sync_q[SYNC_STAGES-1];

  // odd_en flags an uneven duty split; M and C0 are never bypassed, C0 uses counter select 0.
  assign n_word  = {14'd0, (n_hi_q != n_lo_q), n_byp_q, n_hi_q, n_lo_q};
  assign m_word  = {14'd0, (m_hi_q != m_lo_q), 1'b0, m_hi_q, m_lo_q};
  assign c0_word = {9'd0, 5'd0, (c0_hi_q != c0_lo_q), 1'b0, c0_hi_q, c0_lo_q};

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= StIdle;
      m_hi_q    <= '0;
      m_lo_q    <= '0;
      n_hi_q    <= '0;
      n_lo_q    <= '0;
      n_byp_q   <= 1'b0;
      c0_hi_q   <= '0;
      c0_lo_q   <= '0;
      sync_q    <= '0;
      cyc_cnt_q <= '0;
      stable_q  <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      cyc_cnt_q <= cyc_cnt_d;
      stable_q  <= stable_d;
      if (accept) begin
        m_hi_q  <= bus.cfg_m_hi;
        m_lo_q  <= bus.cfg_m_lo;
        n_hi_q  <= bus.cfg_n_hi;
        n_lo_q  <= bus.cfg_n_lo;
        n_byp_q <= bus.cfg_n_bypass;
        c0_hi_q <= bus.cfg_c0_hi;
        c0_lo_q <= bus.cfg_c0_lo;
      end
    end
  end

  // Both counters sit at zero outside WAIT_LOCK, so they start fresh when the start write lands.
  always_comb begin
    cyc_cnt_d = '0;
    stable_d  = '0;
    if (state_q == StWaitLock) begin
      cyc_cnt_d = (cyc_cnt_q == CntW'(LOCK_TIMEOUT)) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
      if (locked_s) begin
        stable_d = (stable_q == StbW'(LOCK_STABLE)) ? stable_q : stable_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.cfg_ready      = 1'b0;
    bus.mgmt_write     = 1'b0;
    bus.mgmt_address   = 6'h00;
    bus.mgmt_writedata = 32'h0;
    done               = 1'b0;
    err_timeout        = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) state_d = StWrMode;
      end
      StWrMode: begin
        bus.mgmt_write = 1'b1;
        if (!bus.mgmt_waitrequest) state_d = StWrN;
      end
      StWrN: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h03;
        bus.mgmt_writedata = n_word;
        if (!bus.mgmt_waitrequest) state_d = StWrM;
      end
      StWrM: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h04;
        bus.mgmt_writedata = m_word;
        if (!bus.mgmt_waitrequest) state_d = StWrC0;
      end
      StWrC0: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h05;
        bus.mgmt_writedata = c0_word;
        if (!bus.mgmt_waitrequest) state_d = StWrStart;
      end
      StWrStart: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h02;
        bus.mgmt_writedata = 32'h1;
        if (!bus.mgmt_waitrequest) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (stable_q == StbW'(LOCK_STABLE)) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (cyc_cnt_q == CntW'(LOCK_TIMEOUT)) begin
          err_timeout = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy = (state_q != StIdle) && !done && !err_timeout;
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench: stimulus pushes expected Avalon writes and done/err events with their
// expected cycle; a negedge monitor pops and compares whenever the DUT completes one.
module tb_pll_reconfig_sequencer;
  localparam int unsigned LockTimeout = 200;
  localparam int unsigned LockStable  = 16;
  localparam int unsigned SyncStages  = 2;

  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic busy, done, err_timeout;

  pll_reconfig_sequencer_if bus();

  pll_reconfig_sequencer #(
    .LOCK_TIMEOUT(LockTimeout),
    .LOCK_STABLE (LockStable),
    .SYNC_STAGES (SyncStages)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .bus        (bus),
    .pll_locked (pll_locked),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge refclk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  typedef struct {int cyc; logic [5:0] addr; logic [31:0] data;} wr_t;
  typedef struct {int cyc; bit is_err;} ev_t;
  wr_t wr_q[$];
  ev_t ev_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor
  logic        hold_v = 1'b0;
  logic [5:0]  hold_a;
  logic [31:0] hold_d;
  always @(negedge refclk) begin
    if (hold_v && !rst_at_edge) begin
      check("hold_write", 64'(bus.mgmt_write), 64'd1);
      check("hold_addr", 64'(bus.mgmt_address), 64'(hold_a));
      check("hold_data", 64'(bus.mgmt_writedata), 64'(hold_d));
    end
    hold_v = bus.mgmt_write && bus.mgmt_waitrequest;
    hold_a = bus.mgmt_address;
    hold_d = bus.mgmt_writedata;
    if (bus.mgmt_write && !bus.mgmt_waitrequest) begin
      if (wr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write at cycle %0d: got addr 0x%0h data 0x%0h, expected none",
                 cyc, bus.mgmt_address, bus.mgmt_writedata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("write_cycle", 64'(cyc), 64'(w.cyc));
        check("write_addr", 64'(bus.mgmt_address), 64'(w.addr));
        check("write_data", 64'(bus.mgmt_writedata), 64'(w.data));
      end
    end
    if (done || err_timeout) begin
      check("busy_at_end", 64'(busy), 64'd0);
      if (ev_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event at cycle %0d: got done=%0b err=%0b, expected none",
                 cyc, done, err_timeout);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        check("event_err", 64'(err_timeout), 64'(e.is_err));
        check("event_done", 64'(done), 64'(!e.is_err));
        check("event_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] mh, input logic [7:0] ml, input logic [7:0] nh,
                         input logic [7:0] nl, input logic nb, input logic [7:0] ch,
                         input logic [7:0] cl);
    bus.cfg_m_hi = mh; bus.cfg_m_lo = ml;
    bus.cfg_n_hi = nh; bus.cfg_n_lo = nl; bus.cfg_n_bypass = nb;
    bus.cfg_c0_hi = ch; bus.cfg_c0_lo = cl;
  endtask

  task automatic push_wr(input int c, input logic [5:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_ev(input int c, input bit is_err);
    ev_t e;
    e.cyc = c; e.is_err = is_err;
    ev_q.push_back(e);
  endtask

  // Five back-to-back writes starting in the accept cycle (no waitrequest).
  task automatic push_seq(input int a, input logic [31:0] nw, input logic [31:0] mw,
                          input logic [31:0] cw);
    push_wr(a,     6'h00, 32'h0);
    push_wr(a + 1, 6'h03, nw);
    push_wr(a + 2, 6'h04, mw);
    push_wr(a + 3, 6'h05, cw);
    push_wr(a + 4, 6'h02, 32'h1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && (wr_q.size() != 0 || ev_q.size() != 0); i++) tick();
    if (wr_q.size() != 0 || ev_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d writes and %0d events outstanding, expected 0",
               name, wr_q.size(), ev_q.size());
      wr_q.delete();
      ev_q.delete();
    end
    @(negedge refclk);
    check({name, "_ready"}, 64'(bus.cfg_ready), 64'd1);
    check({name, "_busy"}, 64'(busy), 64'd0);
    pll_locked = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int a;
    bus.cfg_valid = 1'b0;
    bus.mgmt_waitrequest = 1'b0;
    set_cfg(8'd4, 8'd4, 8'd0, 8'd0, 1'b1, 8'd2, 8'd2);

    // Reset state
    repeat (3) tick();
    @(negedge refclk);
    check("rst_ready", 64'(bus.cfg_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_write", 64'(bus.mgmt_write), 64'd0);
    check("rst_addr", 64'(bus.mgmt_address), 64'd0);
    check("rst_data", 64'(bus.mgmt_writedata), 64'd0);
    check("rst_done_err", 64'({done, err_timeout}), 64'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1) defaults, lock rises 100 cycles after accept
    a = cyc + 1;
    push_seq(a, 32'h0001_0000, 32'h0000_0404, 32'h0000_0202);
    push_ev(a + 100 + SyncStages + LockStable, 1'b0);
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    repeat (100) tick();
    pll_locked = 1'b1;
    wait_idle("t1", 300);

    // 2) odd M, 7 stall cycles on every write
    set_cfg(8'd5, 8'd4, 8'd0, 8'd0, 1'b1, 8'd2, 8'd2);
    a = cyc + 1;
    push_wr(a + 7,  6'h00, 32'h0);
    push_wr(a + 15, 6'h03, 32'h0001_0000);
    push_wr(a + 23, 6'h04, 32'h0002_0504);
    push_wr(a + 31, 6'h05, 32'h0000_0202);
    push_wr(a + 39, 6'h02, 32'h1);
    push_ev(a + 40 + SyncStages + LockStable, 1'b0);
    bus.mgmt_waitrequest = 1'b1;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      bus.mgmt_waitrequest = 1'b1;
      repeat (7) tick();
      bus.mgmt_waitrequest = 1'b0;
      tick();
    end
    pll_locked = 1'b1;
    wait_idle("t2", 300);

    // 3) lock never rises: timeout 200 cycles after the start write completes
    set_cfg(8'd6, 8'd6, 8'd3, 8'd2, 1'b0, 8'd10, 8'd10);
    a = cyc + 1;
    push_seq(a, 32'h0002_0302, 32'h0000_0606, 32'h0000_0A0A);
    push_ev(a + 5 + LockTimeout, 1'b1);
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    wait_idle("t3", 400);

    // 4) lock toggles every 5 cycles for 50 cycles, then holds high
    set_cfg(8'd4, 8'd4, 8'd0, 8'd0, 1'b1, 8'd2, 8'd2);
    a = cyc + 1;
    push_seq(a, 32'h0001_0000, 32'h0000_0404, 32'h0000_0202);
    push_ev(a + 50 + SyncStages + LockStable, 1'b0);
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      pll_locked = ((i / 5) % 2) == 0;
      tick();
    end
    pll_locked = 1'b1;
    wait_idle("t4", 300);

    // 5) reset while WR_M is stalled, then a fresh request
    set_cfg(8'd7, 8'd3, 8'd0, 8'd0, 1'b1, 8'd2, 8'd2);
    a = cyc + 1;
    push_wr(a,     6'h00, 32'h0);
    push_wr(a + 1, 6'h03, 32'h0001_0000);
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    repeat (2) tick();
    bus.mgmt_waitrequest = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    @(negedge refclk);
    check("t5_rst_write", 64'(bus.mgmt_write), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_ready", 64'(bus.cfg_ready), 64'd1);
    check("t5_wr_left", 64'(wr_q.size()), 64'd0);
    tick();
    rst = 1'b0;
    bus.mgmt_waitrequest = 1'b0;
    set_cfg(8'd4, 8'd4, 8'd0, 8'd0, 1'b1, 8'd2, 8'd2);
    a = cyc + 1;
    push_seq(a, 32'h0001_0000, 32'h0000_0404, 32'h0000_0202);
    push_ev(a + 10 + SyncStages + LockStable, 1'b0);
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    repeat (10) tick();
    pll_locked = 1'b1;
    wait_idle("t5", 300);

    // 6) valid held while busy with changing fields: single accept, captured values kept
    set_cfg(8'd8, 8'd8, 8'd1, 8'd1, 1'b0, 8'd3, 8'd2);
    a = cyc + 1;
    push_seq(a, 32'h0000_0101, 32'h0000_0808, 32'h0002_0302);
    push_ev(a + 30 + SyncStages + LockStable, 1'b0);
    bus.cfg_valid = 1'b1;
    tick();
    set_cfg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF);
    repeat (10) tick();
    @(negedge refclk);
    check("t6_busy_mid", 64'(busy), 64'd1);
    check("t6_ready_mid", 64'(bus.cfg_ready), 64'd0);
    repeat (10) tick();
    bus.cfg_valid = 1'b0;
    repeat (10) tick();
    pll_locked = 1'b1;
    wait_idle("t6", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
